infer_batch_ctrl: RTL and testbench

Batch-inference sequencer for the 10-class classifier path. It steps through a test set of `NUM_IMAGES` images, and for each image it pulses the network launch, waits for the argmax comparator's `ready`, and samples the predicted class. It then checks the prediction against a label ROM and accumulates correct and total counts. It sits between the host/testbench control registers and the network-plus-comparator datapath.

---
 rtl/infer_batch_ctrl.sv | 155 +++++++++++++++
 tb/tb_infer_batch_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/infer_batch_ctrl.sv
// infer_batch_ctrl: batch-inference sequencer for the 10-class classifier path.
// For each image it launches the network, waits (bounded) for the comparator's
// ready, then scores the prediction against the label ROM.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | parked, waiting for start; counters hold
// S_LAUNCH | one-cycle net_valid pulse for the image at img_addr
// S_WAIT   | waiting for net_ready, bounded by the wait timer
// S_CHECK  | one-cycle scoring of last_predict against label_data
// S_DONE   | batch complete; results hold until the next start
module infer_batch_ctrl #(
  parameter int NUM_IMAGES  = 10000,
  parameter int ADDR_WIDTH  = 14,
  parameter int CLASS_WIDTH = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   abort_i,
  output logic [ADDR_WIDTH-1:0]  img_addr_o,
  output logic                   net_valid_o,
  input  logic                   net_ready_i,
  input  logic [31:0]            predict_i,
  input  logic [CLASS_WIDTH-1:0] label_data_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   timeout_flag_o,
  output logic [CLASS_WIDTH-1:0] last_predict_o,
  output logic [31:0]            correct_count_o,
  output logic [31:0]            total_count_o
);

  // Wait timer counts down from TIMEOUT-1; terminal count 0 is the last WAIT cycle.
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [TW-1:0]          wait_tmr_q;
  logic                   img_to_q;
  logic [ADDR_WIDTH-1:0]  img_addr_q;
  logic                   net_valid_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   timeout_flag_q;
  logic [CLASS_WIDTH-1:0] last_predict_q;
  logic [31:0]            correct_count_q;
  logic [31:0]            total_count_q;

  logic                   hit_d;
  logic                   last_img_d;
  logic                   unused_predict;

  // Only the class-index bits of the comparator word carry information.
  assign unused_predict = ^predict_i[31:CLASS_WIDTH];

  // Scoring terms for CHECK; a timed-out image never scores.
  always_comb begin
    hit_d      = !img_to_q && (last_predict_q == label_data_i);
    last_img_d = (img_addr_q == ADDR_WIDTH'(NUM_IMAGES - 1));
  end

  // Sequencer FSM with registered outputs; abort overrides every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      wait_tmr_q      <= '0;
      img_to_q        <= 1'b0;
      img_addr_q      <= '0;
      net_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      timeout_flag_q  <= 1'b0;
      last_predict_q  <= '0;
      correct_count_q <= '0;
      total_count_q   <= '0;
    end else if (abort_i) begin
      state_q     <= S_IDLE;
      net_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q         <= S_LAUNCH;
            net_valid_q     <= 1'b1;
            busy_q          <= 1'b1;
            done_q          <= 1'b0;
            img_addr_q      <= '0;
            correct_count_q <= '0;
            total_count_q   <= '0;
            timeout_flag_q  <= 1'b0;
          end
        end
        S_LAUNCH: begin
          state_q     <= S_WAIT;
          net_valid_q <= 1'b0;
          wait_tmr_q  <= TW'(TIMEOUT - 1);
          img_to_q    <= 1'b0;
        end
        S_WAIT: begin
          if (net_ready_i) begin
            last_predict_q <= predict_i[CLASS_WIDTH-1:0];
            state_q        <= S_CHECK;
          end else if (wait_tmr_q == '0) begin
            last_predict_q <= '1;
            timeout_flag_q <= 1'b1;
            img_to_q       <= 1'b1;
            state_q        <= S_CHECK;
          end else begin
            wait_tmr_q <= wait_tmr_q - 1'b1;
          end
        end
        S_CHECK: begin
          total_count_q <= total_count_q + 32'd1;
          if (hit_d) correct_count_q <= correct_count_q + 32'd1;
          if (last_img_d) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            img_addr_q  <= img_addr_q + 1'b1;
            state_q     <= S_LAUNCH;
            net_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          net_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign img_addr_o      = img_addr_q;
  assign net_valid_o     = net_valid_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign timeout_flag_o  = timeout_flag_q;
  assign last_predict_o  = last_predict_q;
  assign correct_count_o = correct_count_q;
  assign total_count_o   = total_count_q;

endmodule

// File: tb/tb_infer_batch_ctrl.sv
// tb_infer_batch_ctrl: scoreboard bench for infer_batch_ctrl with a 4-image
// batch and an 8-cycle wait bound. A responder answers each launch after a
// per-image delay (0 = never) and a label ROM model follows img_addr.
module tb_infer_batch_ctrl;

  localparam int N  = 4;
  localparam int TO = 8;

  typedef struct {
    logic [3:0]  lp;
    logic [31:0] cor;
    logic [31:0] tot;
    logic        flag;
    logic [13:0] addr;
    logic        dn;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        abort_i;
  logic [13:0] img_addr_o;
  logic        net_valid_o;
  logic        net_ready_i;
  logic [31:0] predict_i;
  logic [3:0]  label_data_i;
  logic        busy_o;
  logic        done_o;
  logic        timeout_flag_o;
  logic [3:0]  last_predict_o;
  logic [31:0] correct_count_o;
  logic [31:0] total_count_o;

  infer_batch_ctrl #(
    .NUM_IMAGES (N),
    .ADDR_WIDTH (14),
    .CLASS_WIDTH(4),
    .TIMEOUT    (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .img_addr_o     (img_addr_o),
    .net_valid_o    (net_valid_o),
    .net_ready_i    (net_ready_i),
    .predict_i      (predict_i),
    .label_data_i   (label_data_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .timeout_flag_o (timeout_flag_o),
    .last_predict_o (last_predict_o),
    .correct_count_o(correct_count_o),
    .total_count_o  (total_count_o)
  );

  always #5 clk = ~clk;

  logic [3:0] pred_t[N];
  logic [3:0] lbl_t[N];
  int         dly[N];
  logic       echo = 1'b0;
  logic       force_rdy = 1'b0;

  exp_t exp_q[$];
  int   gap_q[$];
  int   n_asrt = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   nv_cnt = 0;
  int   fire_cyc = -10;
  int   last_launch = 0;
  int   la = 0;
  logic [31:0] prev_total = '0;
  logic [31:0] fin_cor, fin_tot;
  logic        fin_flag;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: expected post-CHECK results for the first n_chk images and
  // launch-to-launch gaps for launches 1..n_launch-1.
  task automatic push_expect(input int n_chk, input int n_launch);
    logic [31:0] cor;
    logic        flag;
    logic        to;
    exp_t        e;
    cor  = 0;
    flag = 1'b0;
    for (int i = 0; i < n_chk; i++) begin
      to = (dly[i] == 0) || (dly[i] > TO);
      e.lp = to ? 4'hF : pred_t[i];
      if (!to && pred_t[i] == lbl_t[i]) cor++;
      flag   = flag | to;
      e.cor  = cor;
      e.tot  = i + 1;
      e.flag = flag;
      e.addr = (i == N - 1) ? 14'(i) : 14'(i + 1);
      e.dn   = (i == N - 1);
      exp_q.push_back(e);
    end
    for (int i = 1; i < n_launch; i++)
      gap_q.push_back(2 + (((dly[i-1] == 0) || (dly[i-1] > TO)) ? TO : dly[i-1]));
    fin_cor  = cor;
    fin_tot  = n_chk;
    fin_flag = flag;
  endtask

  // Monitor, scoreboard pop, ready responder and label ROM, all on the falling edge.
  initial begin
    logic [31:0] r;
    exp_t        e;
    net_ready_i  = 1'b0;
    predict_i    = '0;
    label_data_i = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (net_valid_o) begin
        nv_cnt++;
        la = int'(img_addr_o[1:0]);
        fire_cyc = (dly[la] == 0) ? -10 : cyc + dly[la];
        if (img_addr_o != 0) begin
          if (gap_q.size() == 0) check_val("gap_pop", gap_q.size(), 1);
          else check_val("launch_gap", cyc - last_launch, gap_q.pop_front());
        end
        last_launch = cyc;
      end
      if (total_count_o == prev_total + 32'd1) begin
        if (exp_q.size() == 0) check_val("sb_pop", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check_val("last_predict", last_predict_o, e.lp);
          check_val("correct", correct_count_o, e.cor);
          check_val("total", total_count_o, e.tot);
          check_val("tflag", timeout_flag_o, e.flag);
          check_val("img_addr", img_addr_o, e.addr);
          check_val("done_edge", done_o, e.dn);
        end
      end
      prev_total   = total_count_o;
      label_data_i = lbl_t[img_addr_o[1:0]];
      r            = $urandom;
      net_ready_i  = 1'b0;
      predict_i    = r;
      if (force_rdy) begin
        net_ready_i = 1'b1;
        predict_i   = 32'h0000_0005;
      end else if (cyc == fire_cyc) begin
        r[3:0]      = pred_t[la];
        net_ready_i = 1'b1;
        predict_i   = r;
      end else if (echo && cyc == fire_cyc + 1) begin
        r[3:0]      = 4'hA;
        net_ready_i = 1'b1;
        predict_i   = r;
      end
    end
  end

  task automatic start_batch();
    nv_cnt = 0;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check_val("launch_nv", net_valid_o, 1);
    check_val("launch_busy", busy_o, 1);
    check_val("launch_done", done_o, 0);
    check_val("clr_addr", img_addr_o, 0);
    check_val("clr_total", total_count_o, 0);
    check_val("clr_correct", correct_count_o, 0);
    check_val("clr_tflag", timeout_flag_o, 0);
  endtask

  task automatic wait_done_check(input int n_launch);
    int k;
    k = 0;
    while (!done_o && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_val("done_wait", done_o, 1);
    check_val("end_busy", busy_o, 0);
    check_val("end_correct", correct_count_o, fin_cor);
    check_val("end_total", total_count_o, fin_tot);
    check_val("end_tflag", timeout_flag_o, fin_flag);
    check_val("nv_count", nv_cnt, n_launch);
    check_val("sb_left", exp_q.size(), 0);
    check_val("gap_left", gap_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_addr"}, img_addr_o, 0);
    check_val({tag, "_nv"}, net_valid_o, 0);
    check_val({tag, "_busy"}, busy_o, 0);
    check_val({tag, "_done"}, done_o, 0);
    check_val({tag, "_tflag"}, timeout_flag_o, 0);
    check_val({tag, "_lp"}, last_predict_o, 0);
    check_val({tag, "_correct"}, correct_count_o, 0);
    check_val({tag, "_total"}, total_count_o, 0);
  endtask

  initial begin
    int k;
    rst     = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    pred_t  = '{4'd3, 4'd1, 4'd4, 4'd1};
    lbl_t   = '{4'd3, 4'd1, 4'd5, 4'd1};
    dly     = '{2, 2, 2, 2};
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;

    // Stray ready in IDLE must be ignored.
    @(negedge clk);
    force_rdy = 1'b1;
    @(negedge clk);
    force_rdy = 1'b0;
    @(negedge clk);
    check_val("idle_rdy_lp", last_predict_o, 0);
    check_val("idle_rdy_busy", busy_o, 0);

    // Happy path with a stray ready echoed into every CHECK cycle.
    echo = 1'b1;
    push_expect(N, N);
    start_batch();
    wait_done_check(N);
    echo = 1'b0;

    // Image 2 never answers; a stray start lands in its WAIT.
    dly = '{2, 2, 0, 2};
    push_expect(N, N);
    start_batch();
    k = 0;
    while (!(net_valid_o && img_addr_o == 2) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_val("to_reach_img2", img_addr_o, 2);
    repeat (3) @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check_val("spur_start_busy", busy_o, 1);
    check_val("spur_start_nv", net_valid_o, 0);
    wait_done_check(N);

    // Ready arriving on the last allowed WAIT cycle wins over the timeout.
    dly = '{2, TO, 2, 2};
    push_expect(N, N);
    start_batch();
    wait_done_check(N);

    // Abort in WAIT of image 1, then restart.
    dly = '{2, 2, 2, 2};
    push_expect(1, 2);
    start_batch();
    k = 0;
    while (total_count_o != 1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check_val("abort_busy", busy_o, 0);
    check_val("abort_nv", net_valid_o, 0);
    check_val("abort_done", done_o, 0);
    check_val("abort_total", total_count_o, 1);
    check_val("abort_correct", correct_count_o, fin_cor);
    check_val("abort_addr", img_addr_o, 1);
    repeat (3) @(negedge clk);
    check_val("abort_idle_busy", busy_o, 0);
    check_val("abort_idle_lp", last_predict_o, pred_t[0]);
    check_val("abort_nv_count", nv_cnt, 2);
    check_val("abort_sb_left", exp_q.size(), 0);
    check_val("abort_gap_left", gap_q.size(), 0);
    push_expect(N, N);
    start_batch();
    wait_done_check(N);

    // Reset during CHECK of image 0 drops that CHECK's increment.
    push_expect(0, 1);
    start_batch();
    repeat (3) @(negedge clk);
    check_val("pre_rst_busy", busy_o, 1);
    check_val("pre_rst_total", total_count_o, 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_val("post_rst_total", total_count_o, 0);
    check_val("post_rst_nv_count", nv_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
